// File: rtl/jacobian_column_engine.sv
// Jacobian column generator: one 6-element column per joint from streamed axis/origin data.
// Revolute: lin = z x (p - o), ang = z. Prismatic: lin = z, ang = 0. Two shared multipliers.
module jacobian_column_engine #(
    parameter int NUM_JOINTS = 6,
    parameter int DATA_W     = 27,
    parameter int FRAC_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3*DATA_W-1:0] p_end,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3*DATA_W-1:0] in_z,
    input  logic [3*DATA_W-1:0] in_o,
    input  logic                in_prismatic,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [6*DATA_W-1:0] out_col,
    output logic [3:0]          out_joint,
    output logic                busy,
    output logic                done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_IN = 3'd1;
    localparam logic [2:0] S_DIFF    = 3'd2;
    localparam logic [2:0] S_MUL_X   = 3'd3;
    localparam logic [2:0] S_MUL_Y   = 3'd4;
    localparam logic [2:0] S_MUL_Z   = 3'd5;
    localparam logic [2:0] S_OUT     = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;

    typedef logic signed [DATA_W-1:0] elem_t;

    localparam elem_t ELEM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam elem_t ELEM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Clamp a one-bit-wider difference back to the element range.
    function automatic elem_t sat_diff(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return v[DATA_W] ? ELEM_MIN : ELEM_MAX;
        return v[DATA_W-1:0];
    endfunction

    // Rescale a product difference by 2^-FRAC_W (floor) and clamp to the element range.
    function automatic elem_t sat_prod(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0]  s;
        logic [SUM_W-DATA_W:0]    hi;
        s  = v >>> FRAC_W;
        hi = s[SUM_W-1:DATA_W-1];
        if ((&hi) || (~|hi))
            return s[DATA_W-1:0];
        return s[SUM_W-1] ? ELEM_MIN : ELEM_MAX;
    endfunction

    logic [2:0]                 state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    elem_t                      p_q[3], p_d[3];
    elem_t                      z_q[3], z_d[3];
    elem_t                      o_q[3], o_d[3];
    elem_t                      d_q[3], d_d[3];
    logic                       prism_q, prism_d;
    elem_t                      cx_q, cx_d, cy_q, cy_d;
    logic signed [PROD_W-1:0]   prod_a_q, prod_a_d, prod_b_q, prod_b_d;
    logic                       out_valid_q, out_valid_d;
    logic [6*DATA_W-1:0]        out_col_q, out_col_d;
    logic [3:0]                 out_joint_q, out_joint_d;

    elem_t                      mul_a0, mul_a1, mul_b0, mul_b1;
    logic signed [SUM_W-1:0]    prod_diff;
    elem_t                      cross_val;

    // Operand selection for the two shared multipliers; products land one cycle later.
    always_comb begin
        mul_a0 = '0;
        mul_a1 = '0;
        mul_b0 = '0;
        mul_b1 = '0;
        case (state_q)
            S_MUL_X: begin mul_a0 = z_q[1]; mul_a1 = d_q[2]; mul_b0 = z_q[2]; mul_b1 = d_q[1]; end
            S_MUL_Y: begin mul_a0 = z_q[2]; mul_a1 = d_q[0]; mul_b0 = z_q[0]; mul_b1 = d_q[2]; end
            S_MUL_Z: begin mul_a0 = z_q[0]; mul_a1 = d_q[1]; mul_b0 = z_q[1]; mul_b1 = d_q[0]; end
            default: ;
        endcase
        prod_a_d = PROD_W'(mul_a0) * PROD_W'(mul_a1);
        prod_b_d = PROD_W'(mul_b0) * PROD_W'(mul_b1);
    end

    assign prod_diff = {prod_a_q[PROD_W-1], prod_a_q} - {prod_b_q[PROD_W-1], prod_b_q};
    assign cross_val = sat_prod(prod_diff);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        z_d         = z_q;
        o_d         = o_q;
        d_d         = d_q;
        prism_d     = prism_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_joint_d = out_joint_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < 3; k++) p_d[k] = p_end[k*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    for (int k = 0; k < 3; k++) begin
                        z_d[k] = in_z[k*DATA_W +: DATA_W];
                        o_d[k] = in_o[k*DATA_W +: DATA_W];
                    end
                    prism_d = in_prismatic;
                    state_d = S_DIFF;
                end
            end
            S_DIFF: begin
                for (int k = 0; k < 3; k++)
                    d_d[k] = sat_diff({p_q[k][DATA_W-1], p_q[k]} - {o_q[k][DATA_W-1], o_q[k]});
                state_d = S_MUL_X;
            end
            S_MUL_X: state_d = S_MUL_Y;
            S_MUL_Y: begin
                cx_d    = cross_val;
                state_d = S_MUL_Z;
            end
            S_MUL_Z: begin
                cy_d    = cross_val;
                state_d = S_OUT;
            end
            S_OUT: begin
                // First OUT cycle finishes c_z and loads the column; afterwards it is held.
                if (!out_valid_q) begin
                    if (prism_q)
                        out_col_d = {{(3*DATA_W){1'b0}}, z_q[2], z_q[1], z_q[0]};
                    else
                        out_col_d = {z_q[2], z_q[1], z_q[0], cross_val, cy_q, cx_q};
                    out_joint_d = cnt_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == 4'(NUM_JOINTS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            for (int k = 0; k < 3; k++) begin
                p_q[k] <= '0;
                z_q[k] <= '0;
                o_q[k] <= '0;
                d_q[k] <= '0;
            end
            prism_q     <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            prod_a_q    <= '0;
            prod_b_q    <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_joint_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            z_q         <= z_d;
            o_q         <= o_d;
            d_q         <= d_d;
            prism_q     <= prism_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            prod_a_q    <= prod_a_d;
            prod_b_q    <= prod_b_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_joint_q <= out_joint_d;
        end
    end

    assign in_ready  = (state_q == S_WAIT_IN);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_joint = out_joint_q;

endmodule

// File: tb/tb_jacobian_column_engine.sv
// Self-checking bench for jacobian_column_engine: directed and random joints against an
// integer-arithmetic reference of the column equations, including saturation and reset cases.
module tb_jacobian_column_engine;

    localparam int NJ = 6;
    localparam int DW = 27;
    localparam int FW = 16;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [3*DW-1:0] p_end;
    logic            in_valid;
    logic            in_ready;
    logic [3*DW-1:0] in_z;
    logic [3*DW-1:0] in_o;
    logic            in_prismatic;
    logic            out_valid;
    logic            out_ready;
    logic [6*DW-1:0] out_col;
    logic [3:0]      out_joint;
    logic            busy;
    logic            done;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [3*DW-1:0] cur_p;

    jacobian_column_engine #(.NUM_JOINTS(NJ), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk(clk), .reset(reset), .start(start), .p_end(p_end),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_o(in_o),
        .in_prismatic(in_prismatic), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_joint(out_joint), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic longint clamp(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic logic [3*DW-1:0] pack3(input longint x, input longint y, input longint z);
        return {DW'(z), DW'(y), DW'(x)};
    endfunction

    function automatic logic [6*DW-1:0] pack6(input longint lx, input longint ly, input longint lz,
                                              input longint ax, input longint ay, input longint az);
        return {DW'(az), DW'(ay), DW'(ax), DW'(lz), DW'(ly), DW'(lx)};
    endfunction

    function automatic longint rnd_elem(input bit full);
        if (full) return longint'($signed(DW'($urandom())));
        return longint'($urandom_range(0, 262143)) - 131072;
    endfunction

    function automatic logic [3*DW-1:0] rnd_vec(input bit full);
        return pack3(rnd_elem(full), rnd_elem(full), rnd_elem(full));
    endfunction

    // Reference: column from the geometric definition using wide integer arithmetic.
    function automatic logic [6*DW-1:0] model_col(input logic [3*DW-1:0] p, input logic [3*DW-1:0] o,
                                                  input logic [3*DW-1:0] z, input bit prism);
        longint pv[3], ov[3], zv[3], d[3], lin[3], ang[3];
        for (int k = 0; k < 3; k++) begin
            pv[k] = longint'($signed(p[DW*k +: DW]));
            ov[k] = longint'($signed(o[DW*k +: DW]));
            zv[k] = longint'($signed(z[DW*k +: DW]));
            d[k]  = clamp(pv[k] - ov[k]);
        end
        if (prism) begin
            for (int k = 0; k < 3; k++) begin
                lin[k] = zv[k];
                ang[k] = 0;
            end
        end else begin
            lin[0] = clamp((zv[1] * d[2] - zv[2] * d[1]) >>> FW);
            lin[1] = clamp((zv[2] * d[0] - zv[0] * d[2]) >>> FW);
            lin[2] = clamp((zv[0] * d[1] - zv[1] * d[0]) >>> FW);
            for (int k = 0; k < 3; k++) ang[k] = zv[k];
        end
        return pack6(lin[0], lin[1], lin[2], ang[0], ang[1], ang[2]);
    endfunction

    task automatic check(input string tag, input logic [6*DW-1:0] obs, input logic [6*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idx(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_in_ready"}, in_ready, 1'b0);
        check_bit({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_col"}, out_col, '0);
        check_idx({tag, "_out_joint"}, out_joint, 4'd0);
    endtask

    task automatic start_jac(input logic [3*DW-1:0] p);
        cur_p = p;
        p_end = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        p_end = ~p;
        check_bit("start_busy", busy, 1'b1);
        check_bit("start_in_ready", in_ready, 1'b1);
    endtask

    // One joint: handshake, fixed latency, column, optional back-pressure, column handshake.
    task automatic do_joint(input logic [3*DW-1:0] z, input logic [3*DW-1:0] o, input bit prism,
                            input int idx, input int stall,
                            input bit use_fixed, input logic [6*DW-1:0] fixed);
        logic [6*DW-1:0] exp;
        int waited;
        exp = model_col(cur_p, o, z, prism);
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_bit($sformatf("j%0d_in_ready", idx), in_ready, 1'b1);
        in_z = z;
        in_o = o;
        in_prismatic = prism;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_z = ~z;
        in_o = ~o;
        in_prismatic = ~prism;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_bit($sformatf("j%0d_lat_e%0d_out_valid", idx, e), out_valid, 1'b0);
            check_bit($sformatf("j%0d_lat_e%0d_in_ready", idx, e), in_ready, 1'b0);
        end
        tick();
        check_bit($sformatf("j%0d_lat_e5_out_valid", idx), out_valid, 1'b1);
        check($sformatf("j%0d_col", idx), out_col, exp);
        check_idx($sformatf("j%0d_joint", idx), out_joint, 4'(idx));
        if (use_fixed) check($sformatf("j%0d_col_const", idx), out_col, fixed);
        for (int s = 0; s < stall; s++) begin
            if (s == 3) begin
                start = 1'b1;
                p_end = ~cur_p;
            end
            if (s == 4) start = 1'b0;
            tick();
            check_bit($sformatf("j%0d_stall%0d_valid", idx, s), out_valid, 1'b1);
            check($sformatf("j%0d_stall%0d_col", idx, s), out_col, exp);
            check_idx($sformatf("j%0d_stall%0d_joint", idx, s), out_joint, 4'(idx));
            check_bit($sformatf("j%0d_stall%0d_in_ready", idx, s), in_ready, 1'b0);
            check_bit($sformatf("j%0d_stall%0d_busy", idx, s), busy, 1'b1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (idx == NJ - 1) begin
            check_bit("last_done", done, 1'b1);
            check_bit("last_busy", busy, 1'b0);
            check_bit("last_out_valid", out_valid, 1'b0);
            start = 1'b1;
            p_end = ~cur_p;
            tick();
            start = 1'b0;
            check_bit("after_done_pulse", done, 1'b0);
            check_bit("after_done_busy", busy, 1'b0);
            check_bit("after_done_in_ready", in_ready, 1'b0);
            tick();
            check_bit("idle_in_ready", in_ready, 1'b0);
            check_bit("idle_busy", busy, 1'b0);
            check_bit("idle_done", done, 1'b0);
        end else begin
            check_bit($sformatf("j%0d_post_done", idx), done, 1'b0);
            check_bit($sformatf("j%0d_post_valid", idx), out_valid, 1'b0);
            check_bit($sformatf("j%0d_post_in_ready", idx), in_ready, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        p_end = '0;
        in_valid = 1'b0;
        in_z = '0;
        in_o = '0;
        in_prismatic = 1'b0;
        out_ready = 1'b0;
        #2;
        check_all_zero("reset");
        #10;
        reset = 1'b0;
        tick();

        // in_valid with no active Jacobian is never taken.
        in_valid = 1'b1;
        in_z = rnd_vec(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("idle_valid_in_ready", in_ready, 1'b0);
            check_bit("idle_valid_busy", busy, 1'b0);
            check_bit("idle_valid_out_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;

        // Jacobian A: basic revolute, prismatic, back-pressure with ignored start, random.
        start_jac(pack3(65536, 0, 0));
        do_joint(pack3(0, 0, 65536), pack3(0, 0, 0), 1'b0, 0, 0, 1'b1,
                 pack6(0, 65536, 0, 0, 0, 65536));
        do_joint(pack3(65536, 0, 0), rnd_vec(1'b0), 1'b1, 1, 0, 1'b1,
                 pack6(65536, 0, 0, 0, 0, 0));
        do_joint(rnd_vec(1'b0), rnd_vec(1'b0), 1'b0, 2, 10, 1'b0, '0);
        for (int j = 3; j < NJ; j++)
            do_joint(rnd_vec(1'b0), rnd_vec(1'b0), 1'b0, j, j - 3, 1'b0, '0);

        // Jacobian B: positive saturation of d and c, negative mirror via z, full-range random.
        start_jac(pack3(MAXV, 0, 0));
        do_joint(pack3(0, 0, 131072), pack3(-MAXV, 0, 0), 1'b0, 0, 0, 1'b1,
                 pack6(0, MAXV, 0, 0, 0, 131072));
        do_joint(pack3(0, 0, -131072), pack3(-MAXV, 0, 0), 1'b0, 1, 0, 1'b1,
                 pack6(0, MINV, 0, 0, 0, -131072));
        for (int j = 2; j < NJ; j++)
            do_joint(rnd_vec(1'b1), rnd_vec(1'b1), j[0], j, 1, 1'b0, '0);

        // Jacobian C: negative saturation of d.
        start_jac(pack3(MINV, 0, 0));
        do_joint(pack3(0, 0, 131072), pack3(MAXV, 0, 0), 1'b0, 0, 0, 1'b1,
                 pack6(0, MINV, 0, 0, 0, 131072));
        for (int j = 1; j < NJ; j++)
            do_joint(rnd_vec(1'b1), rnd_vec(1'b0), 1'b0, j, 0, 1'b0, '0);

        // Asynchronous reset while the first joint is in MUL_Y.
        start_jac(rnd_vec(1'b0));
        in_z = rnd_vec(1'b0);
        in_o = rnd_vec(1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        #2;
        reset = 1'b0;
        tick();
        check_bit("post_reset_busy", busy, 1'b0);
        check_bit("post_reset_in_ready", in_ready, 1'b0);
        tick();
        check_bit("post_reset_out_valid", out_valid, 1'b0);

        // Jacobian D: clean run after reset.
        start_jac(rnd_vec(1'b0));
        for (int j = 0; j < NJ; j++)
            do_joint(rnd_vec(1'b0), rnd_vec(1'b0), (j == 4), j, 0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
